// File: rtl/sd_stim_ctrl.sv
// Stimulus sequencer for the sequence detector: shifts a pattern word MSB-first onto x,
// repeats it back-to-back, drains, and counts detector pulses over the run.
module sd_stim_ctrl #(
    parameter int DW    = 24,
    parameter int LEN_W = 5,
    parameter int REP_W = 4,
    parameter int CNT_W = 8,
    parameter int DRAIN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [DW-1:0]    word,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] reps,
    input  logic             det_y,
    output logic             x,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             hit_ovf
);

    // state   | meaning
    // S_IDLE  | waiting for start, x=0
    // S_SHIFT | pattern bits on x, passes repeated without gap
    // S_DRAIN | x=0 for DRAIN cycles, det_y still counted
    // S_DONE  | one-cycle done pulse
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DRAIN, S_DONE} state_t;

    localparam int DR_W = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    state_t           state;
    logic [DW-1:0]    word_q;
    logic [DW-1:0]    sreg;
    logic [LEN_W-1:0] len_m1;
    logic [LEN_W-1:0] bit_rem;
    logic [REP_W-1:0] pass_rem;
    logic [DR_W-1:0]  drain_rem;
    logic [LEN_W-1:0] eff_len_m1;
    logic [REP_W-1:0] eff_reps_m1;
    logic             counting;

    always_comb begin
        eff_len_m1 = len - 1'b1;
        if (len == '0 || int'(len) > DW)
            eff_len_m1 = LEN_W'(DW - 1);
        eff_reps_m1 = reps - 1'b1;
        if (reps == '0)
            eff_reps_m1 = '0;
    end

    assign counting = (state == S_SHIFT) || (state == S_DRAIN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            word_q    <= '0;
            sreg      <= '0;
            len_m1    <= '0;
            bit_rem   <= '0;
            pass_rem  <= '0;
            drain_rem <= '0;
            x         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hit_cnt   <= '0;
            hit_ovf   <= 1'b0;
        end else begin
            done <= 1'b0;

            // Counting and clearing never coincide: clear happens only in IDLE.
            if (counting && det_y) begin
                if (hit_cnt == {CNT_W{1'b1}})
                    hit_ovf <= 1'b1;
                else
                    hit_cnt <= hit_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    x <= 1'b0;
                    if (start) begin
                        word_q   <= word;
                        sreg     <= word << 1;
                        x        <= word[DW-1];
                        len_m1   <= eff_len_m1;
                        bit_rem  <= eff_len_m1;
                        pass_rem <= eff_reps_m1;
                        hit_cnt  <= '0;
                        hit_ovf  <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        x     <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (bit_rem == '0) begin
                        if (pass_rem == '0) begin
                            x <= 1'b0;
                            if (DRAIN == 0) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                drain_rem <= DR_W'(DRAIN - 1);
                                state     <= S_DRAIN;
                            end
                        end else begin
                            pass_rem <= pass_rem - 1'b1;
                            bit_rem  <= len_m1;
                            x        <= word_q[DW-1];
                            sreg     <= word_q << 1;
                        end
                    end else begin
                        bit_rem <= bit_rem - 1'b1;
                        x       <= sreg[DW-1];
                        sreg    <= sreg << 1;
                    end
                end
                S_DRAIN: begin
                    x <= 1'b0;
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (drain_rem == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        drain_rem <= drain_rem - 1'b1;
                    end
                end
                default: begin
                    x     <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_stim_ctrl.sv
// Bench for sd_stim_ctrl: directed cases plus randomized runs scored against a
// per-cycle expectation derived from word/len/reps/abort timing.
module tb_sd_stim_ctrl;
    localparam int DW = 24;
    localparam int CW = 4;
    localparam int DR = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          det_y = 1'b0;
    logic [DW-1:0] word = '0;
    logic [4:0]    len = '0;
    logic [3:0]    reps = '0;
    logic          x, busy, done, hit_ovf;
    logic [CW-1:0] hit_cnt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sd_stim_ctrl #(.DW(DW), .LEN_W(5), .REP_W(4), .CNT_W(CW), .DRAIN(DR)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .word(word),
        .len(len), .reps(reps), .det_y(det_y), .x(x), .busy(busy),
        .done(done), .hit_cnt(hit_cnt), .hit_ovf(hit_ovf)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_x"}, 32'(x), 0);
        check_val({tag, "_busy"}, 32'(busy), 0);
        check_val({tag, "_done"}, 32'(done), 0);
        check_val({tag, "_hit_cnt"}, 32'(hit_cnt), 0);
        check_val({tag, "_hit_ovf"}, 32'(hit_ovf), 0);
    endtask

    // det_mode: 0 none, 1 always, 2 random, 3 pulses in cycles 1 and 3
    task automatic run_case(input string tag, input logic [DW-1:0] w, input logic [4:0] l,
                            input logic [3:0] r, input int abort_at, input int det_mode,
                            input bit hold);
        int  L, R, T, last, m_cnt;
        bit  m_ovf, ab, exp_x;
        logic dv;
        L = (l == 0 || l > DW) ? DW : int'(l);
        R = (r == 0) ? 1 : int'(r);
        T = L * R + DR;
        last = (abort_at > 0) ? abort_at + 2 : (hold ? T + 3 : T + 2);
        m_cnt = 0;
        m_ovf = 1'b0;

        @(negedge clk);
        start = 1'b1; word = w; len = l; reps = r; abort = 1'b0; det_y = 1'b0;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (hold && k == T + 3) begin
                check_val({tag, "_restart_busy"}, 32'(busy), 1);
                check_val({tag, "_restart_x"}, 32'(x), 32'(w[DW-1]));
                check_val({tag, "_restart_hit"}, 32'(hit_cnt), 0);
                check_val({tag, "_restart_done"}, 32'(done), 0);
            end else begin
                ab = (abort_at > 0 && abort_at < k);
                exp_x = (!ab && k <= L * R) ? w[DW - 1 - ((k - 1) % L)] : 1'b0;
                check_val({tag, "_x"}, 32'(x), 32'(exp_x));
                check_val({tag, "_busy"}, 32'(busy), 32'(!ab && k <= T));
                check_val({tag, "_done"}, 32'(done), 32'(!ab && k == T + 1));
                check_val({tag, "_hit_cnt"}, 32'(hit_cnt), 32'(m_cnt));
                check_val({tag, "_hit_ovf"}, 32'(hit_ovf), 32'(m_ovf));
            end

            case (det_mode)
                0:       dv = 1'b0;
                1:       dv = 1'b1;
                2:       dv = ($urandom_range(0, 3) == 0);
                default: dv = (k == 1 || k == 3);
            endcase
            det_y = dv;
            abort = (k == abort_at) || (hold && k == T + 3);
            if (hold)
                start = 1'b1;
            else if (k <= T && (abort_at == 0 || k <= abort_at))
                start = 1'($urandom_range(0, 1));
            else
                start = 1'b0;
            if (!hold) begin
                word = DW'($urandom);
                len  = 5'($urandom);
                reps = 4'($urandom);
            end
            if (k <= T && !(abort_at > 0 && abort_at < k) && dv) begin
                if (m_cnt == CMAX) m_ovf = 1'b1;
                else m_cnt++;
            end
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0; det_y = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1 rst = 1'b0;
        #1 check_reset_vals("t1_initial");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("t1_idle");

        run_case("t2", 24'h0C9094, 5'd0, 4'd0, 0, 0, 1'b0);
        run_case("t3", 24'hA00000, 5'd4, 4'd3, 0, 2, 1'b0);
        run_case("t4", 24'h5A5A5A, 5'd24, 4'd1, 0, 1, 1'b0);
        run_case("t5", 24'h0C9094, 5'd0, 4'd0, 5, 3, 1'b0);
        run_case("t6", 24'hA00000, 5'd4, 4'd3, 0, 0, 1'b1);
        run_case("len1", 24'h800000, 5'd1, 4'd2, 0, 2, 1'b0);
        run_case("len_over", 24'h123456, 5'd31, 4'd1, 0, 2, 1'b0);
        run_case("abort_drain", 24'hFFFFFF, 5'd3, 4'd1, 4, 1, 1'b0);

        // Asynchronous reset mid-SHIFT, asserted between clock edges.
        @(negedge clk);
        start = 1'b1; word = 24'hFFFFFF; len = 5'd8; reps = 4'd2; det_y = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_reset_vals("t1_midrun");
        @(negedge clk);
        rst = 1'b1; det_y = 1'b0;
        @(negedge clk);
        check_reset_vals("t1_after");

        for (int i = 0; i < 40; i++) begin
            logic [DW-1:0] rw;
            logic [4:0]    rl;
            logic [3:0]    rr;
            int            rt, ra;
            rw = DW'($urandom);
            rl = 5'($urandom);
            rr = 4'($urandom_range(0, 6));
            rt = ((rl == 0 || rl > DW) ? DW : int'(rl)) * ((rr == 0) ? 1 : int'(rr)) + DR;
            ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, rt)) : 0;
            run_case("rand", rw, rl, rr, ra, 2, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
